// File: rtl/step_pulse_generator_pkg.sv
// Shared types and period arithmetic helpers for the step pulse generator.
package step_pulse_generator_pkg;

  localparam int unsigned DEF_STEP_W = 16;
  localparam int unsigned DEF_PER_W  = 16;
  localparam int unsigned CALC_W     = 32;

  typedef logic [CALC_W-1:0] calc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEL,
    ST_CRUISE,
    ST_DECEL
  } state_e;

  function automatic calc_t max_u(input calc_t a, input calc_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic calc_t min_u(input calc_t a, input calc_t b);
    return (a < b) ? a : b;
  endfunction

  // a - b, floored at lo without wrapping below zero
  function automatic calc_t sub_floor(input calc_t a, input calc_t b, input calc_t lo);
    return (a >= lo + b) ? a - b : lo;
  endfunction

endpackage

// File: rtl/step_pulse_generator_if.sv
// Command handshake and step output bundle between motion planner and sequencer.
interface step_pulse_generator_if
  import step_pulse_generator_pkg::*;
#(
  parameter int unsigned STEP_W = DEF_STEP_W,
  parameter int unsigned PER_W  = DEF_PER_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_dir;
  logic [PER_W-1:0]  cmd_period;
  logic              abort;
  logic              step_pulse;
  logic              step_dir;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [STEP_W-1:0] steps_remaining;

  modport master (
    output cmd_valid, cmd_steps, cmd_dir, cmd_period, abort,
    input  cmd_ready, step_pulse, step_dir, busy, done, aborted, steps_remaining
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir, cmd_period, abort,
    output cmd_ready, step_pulse, step_dir, busy, done, aborted, steps_remaining
  );
endinterface

// File: rtl/step_pulse_generator_timer.sv
// Loadable period down-counter; expire_c marks the cycle a step is due.
module step_period_timer #(
  parameter int unsigned PER_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             load,
  input  logic [PER_W-1:0] load_val,
  output logic             expire_c
);
  logic [PER_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (run && (cnt_q != '0)) begin
      cnt_q <= cnt_q - PER_W'(1);
    end
  end

  // Loaded with P, counter reaches 1 exactly P cycles after the load edge
  assign expire_c = run && (cnt_q == PER_W'(1));

endmodule

// File: rtl/step_pulse_generator.sv
// Trapezoidal step pulse profile generator: accel / cruise / decel per step.
module step_pulse_generator
  import step_pulse_generator_pkg::*;
#(
  parameter int unsigned STEP_W       = DEF_STEP_W,
  parameter int unsigned PER_W        = DEF_PER_W,
  parameter int unsigned START_PERIOD = 1000,
  parameter int unsigned ACCEL_DEC    = 10,
  parameter int unsigned MIN_PERIOD   = 2
) (
  input logic                   clk,
  input logic                   reset,
  step_pulse_generator_if.slave bus
);

  state_e            state_q, state_d;
  logic [PER_W-1:0]  cur_q, cur_d;
  logic [PER_W-1:0]  target_q, target_d;
  logic [STEP_W-1:0] ramp_q, ramp_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              dir_q, dir_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic              tmr_load;
  logic [PER_W-1:0]  tmr_val;
  logic              tmr_expire;
  logic              pulse_c;
  logic [STEP_W-1:0] rem_next;
  calc_t             tgt_new, cur_new, cur_up, cur_dn;

  step_period_timer #(.PER_W(PER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .run      (busy_q),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire_c (tmr_expire)
  );

  // abort in the expiry cycle suppresses that pulse
  assign pulse_c  = tmr_expire && !bus.abort;
  assign rem_next = rem_q - STEP_W'(1);
  assign tgt_new  = max_u(CALC_W'(bus.cmd_period), CALC_W'(MIN_PERIOD));
  assign cur_new  = max_u(CALC_W'(START_PERIOD), tgt_new);
  assign cur_up   = min_u(CALC_W'(cur_q) + CALC_W'(ACCEL_DEC), CALC_W'(START_PERIOD));
  assign cur_dn   = sub_floor(CALC_W'(cur_q), CALC_W'(ACCEL_DEC), CALC_W'(target_q));

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    target_d  = target_q;
    ramp_d    = ramp_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = cur_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          dir_d    = bus.cmd_dir;
          rem_d    = bus.cmd_steps;
          target_d = PER_W'(tgt_new);
          cur_d    = PER_W'(cur_new);
          ramp_d   = '0;
          if (bus.cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = PER_W'(cur_new);
            state_d  = (tgt_new >= CALC_W'(START_PERIOD)) ? ST_CRUISE : ST_ACCEL;
          end
        end
      end
      default: begin
        if (bus.abort) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (pulse_c) begin
          rem_d = rem_next;
          if (rem_next == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            // enough ramp-down steps left takes priority over accelerating
            if (rem_next <= ramp_q) begin
              state_d = ST_DECEL;
              cur_d   = PER_W'(cur_up);
              ramp_d  = (ramp_q == '0) ? '0 : ramp_q - STEP_W'(1);
            end else if (state_q == ST_ACCEL) begin
              cur_d  = PER_W'(cur_dn);
              ramp_d = ramp_q + STEP_W'(1);
              if (cur_dn == CALC_W'(target_q)) begin
                state_d = ST_CRUISE;
              end
            end
            tmr_load = 1'b1;
            tmr_val  = cur_d;
          end
        end
      end
    endcase

    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      target_q  <= '0;
      ramp_q    <= '0;
      rem_q     <= '0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      target_q  <= target_d;
      ramp_q    <= ramp_d;
      rem_q     <= rem_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.cmd_ready       = ready_q;
  assign bus.step_pulse      = pulse_c;
  assign bus.step_dir        = dir_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.aborted         = aborted_q;
  assign bus.steps_remaining = rem_q;

endmodule

// File: tb/tb_step_pulse_generator.sv
// Bench for step_pulse_generator: directed profile cases plus randomized moves vs a behavioural model.
module tb_step_pulse_generator;

  localparam int unsigned STEP_W = 16;
  localparam int unsigned PER_W  = 16;
  localparam int START_P = 10;
  localparam int DEC_P   = 2;
  localparam int MIN_P   = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  step_pulse_generator_if #(.STEP_W(STEP_W), .PER_W(PER_W)) bus ();

  step_pulse_generator #(
    .STEP_W       (STEP_W),
    .PER_W        (PER_W),
    .START_PERIOD (START_P),
    .ACCEL_DEC    (DEC_P),
    .MIN_PERIOD   (MIN_P)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  int obs_pulses[$];
  int obs_done;
  int obs_rem;
  bit obs_aborted;
  bit obs_dir_ok;
  bit obs_ready_done;

  int exp_pulses[$];
  int exp_done;
  int exp_rem;
  bit exp_aborted;

  // Pulse schedule from the profile rules, as absolute cycles after accept
  task automatic model(input int steps, input int period, input int abort_at);
    int tgt, cur, ramp, t, rem;
    bit ramping;
    exp_pulses.delete();
    exp_aborted = 1'b0;
    exp_rem = 0;
    if (steps == 0) begin
      exp_done = 1;
      return;
    end
    tgt = (period < MIN_P) ? MIN_P : period;
    cur = (tgt > START_P) ? tgt : START_P;
    ramping = (tgt < START_P);
    ramp = 0;
    t = 0;
    for (int i = 1; i <= steps; i++) begin
      t += cur;
      if (abort_at > 0 && abort_at <= t) begin
        exp_done = abort_at + 1;
        exp_aborted = 1'b1;
        exp_rem = steps - i + 1;
        return;
      end
      exp_pulses.push_back(t);
      rem = steps - i;
      if (rem == 0) begin
        exp_done = t + 1;
        return;
      end
      if (rem <= ramp) begin
        ramping = 1'b0;
        cur = (cur + DEC_P > START_P) ? START_P : cur + DEC_P;
        if (ramp > 0) ramp--;
      end else if (ramping) begin
        cur = (cur - DEC_P < tgt) ? tgt : cur - DEC_P;
        ramp++;
        if (cur == tgt) ramping = 1'b0;
      end
    end
  endtask

  // Offer one command in cycle 0 and record what the DUT does until done
  task automatic run_move(input int steps, input bit dir, input int period,
                          input int abort_at, input int limit, input bit noise);
    obs_pulses.delete();
    obs_done = -1;
    obs_rem = -1;
    obs_aborted = 1'b0;
    obs_dir_ok = 1'b1;
    obs_ready_done = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_steps  = STEP_W'(steps);
    bus.cmd_dir    = dir;
    bus.cmd_period = PER_W'(period);
    bus.abort      = 1'b0;
    for (int k = 1; k <= limit && obs_done < 0; k++) begin
      @(posedge clk); #1;
      bus.abort = (k == abort_at);
      if (noise && bus.busy) begin
        bus.cmd_valid  = 1'($urandom_range(0, 1));
        bus.cmd_steps  = STEP_W'($urandom_range(0, 40));
        bus.cmd_dir    = ~dir;
        bus.cmd_period = PER_W'($urandom_range(0, 30));
      end else begin
        bus.cmd_valid = 1'b0;
      end
      #1;
      if (bus.step_pulse) obs_pulses.push_back(k);
      if (bus.busy && bus.step_dir !== dir) obs_dir_ok = 1'b0;
      if (bus.done) begin
        obs_done = k;
        obs_aborted = bus.aborted;
        obs_rem = int'(bus.steps_remaining);
        obs_ready_done = bus.cmd_ready;
      end
    end
    bus.abort = 1'b0;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.aborted !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got ready=%b busy=%b done=%b aborted=%b want 1 0 0 0",
               bus.cmd_ready, bus.busy, bus.done, bus.aborted);
    end
    checks++;
    if (bus.steps_remaining !== '0 || bus.step_pulse !== 1'b0 || bus.step_dir !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got rem=%0d pulse=%b dir=%b want 0 0 0",
               bus.steps_remaining, bus.step_pulse, bus.step_dir);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_trapezoid();
    run_move(8, 1'b1, 4, 0, 80, 1'b0);
    exp_pulses = {10, 18, 24, 28, 32, 38, 46, 56};
    checks++;
    if (obs_pulses.size() != exp_pulses.size()) begin
      errors++;
      $display("FAIL trap_count got %0d want %0d", obs_pulses.size(), exp_pulses.size());
    end
    for (int i = 0; i < exp_pulses.size() && i < obs_pulses.size(); i++) begin
      checks++;
      if (obs_pulses[i] != exp_pulses[i]) begin
        errors++;
        $display("FAIL trap_pulse%0d got cycle %0d want %0d", i, obs_pulses[i], exp_pulses[i]);
      end
    end
    checks++;
    if (obs_done != 57 || obs_aborted !== 1'b0 || obs_rem != 0) begin
      errors++;
      $display("FAIL trap_done got cycle %0d aborted=%b rem=%0d want 57 0 0", obs_done, obs_aborted, obs_rem);
    end
    checks++;
    if (!obs_dir_ok) begin
      errors++;
      $display("FAIL trap_dir got unstable step_dir want 1");
    end
  endtask

  task automatic test_triangle();
    run_move(4, 1'b0, 4, 0, 60, 1'b0);
    exp_pulses = {10, 18, 24, 32};
    checks++;
    if (obs_pulses.size() != exp_pulses.size()) begin
      errors++;
      $display("FAIL tri_count got %0d want %0d", obs_pulses.size(), exp_pulses.size());
    end
    for (int i = 0; i < exp_pulses.size() && i < obs_pulses.size(); i++) begin
      checks++;
      if (obs_pulses[i] != exp_pulses[i]) begin
        errors++;
        $display("FAIL tri_pulse%0d got cycle %0d want %0d", i, obs_pulses[i], exp_pulses[i]);
      end
    end
    checks++;
    if (obs_done != 33 || obs_aborted !== 1'b0 || !obs_dir_ok) begin
      errors++;
      $display("FAIL tri_done got cycle %0d aborted=%b dir_ok=%b want 33 0 1", obs_done, obs_aborted, obs_dir_ok);
    end
  endtask

  task automatic test_no_ramp();
    run_move(3, 1'b1, 20, 0, 80, 1'b0);
    exp_pulses = {20, 40, 60};
    checks++;
    if (obs_pulses.size() != exp_pulses.size()) begin
      errors++;
      $display("FAIL noramp_count got %0d want %0d", obs_pulses.size(), exp_pulses.size());
    end
    for (int i = 0; i < exp_pulses.size() && i < obs_pulses.size(); i++) begin
      checks++;
      if (obs_pulses[i] != exp_pulses[i]) begin
        errors++;
        $display("FAIL noramp_pulse%0d got cycle %0d want %0d", i, obs_pulses[i], exp_pulses[i]);
      end
    end
    checks++;
    if (obs_done != 61 || obs_aborted !== 1'b0) begin
      errors++;
      $display("FAIL noramp_done got cycle %0d aborted=%b want 61 0", obs_done, obs_aborted);
    end
  endtask

  task automatic test_zero_and_min();
    run_move(0, 1'b1, 7, 0, 10, 1'b0);
    checks++;
    if (obs_done != 1 || obs_aborted !== 1'b0 || obs_pulses.size() != 0) begin
      errors++;
      $display("FAIL zero_steps got done cycle %0d aborted=%b pulses=%0d want 1 0 0",
               obs_done, obs_aborted, obs_pulses.size());
    end
    run_move(2, 1'b1, 0, 0, 40, 1'b0);
    exp_pulses = {10, 18};
    checks++;
    if (obs_pulses.size() != exp_pulses.size()) begin
      errors++;
      $display("FAIL minper_count got %0d want %0d", obs_pulses.size(), exp_pulses.size());
    end
    for (int i = 0; i < exp_pulses.size() && i < obs_pulses.size(); i++) begin
      checks++;
      if (obs_pulses[i] != exp_pulses[i]) begin
        errors++;
        $display("FAIL minper_pulse%0d got cycle %0d want %0d", i, obs_pulses[i], exp_pulses[i]);
      end
    end
    checks++;
    if (obs_done != 19) begin
      errors++;
      $display("FAIL minper_done got cycle %0d want 19", obs_done);
    end
  endtask

  task automatic test_abort();
    run_move(8, 1'b1, 4, 24, 60, 1'b0);
    exp_pulses = {10, 18};
    checks++;
    if (obs_pulses.size() != exp_pulses.size()) begin
      errors++;
      $display("FAIL abort_count got %0d want %0d", obs_pulses.size(), exp_pulses.size());
    end
    for (int i = 0; i < exp_pulses.size() && i < obs_pulses.size(); i++) begin
      checks++;
      if (obs_pulses[i] != exp_pulses[i]) begin
        errors++;
        $display("FAIL abort_pulse%0d got cycle %0d want %0d", i, obs_pulses[i], exp_pulses[i]);
      end
    end
    checks++;
    if (obs_done != 25 || obs_aborted !== 1'b1) begin
      errors++;
      $display("FAIL abort_done got cycle %0d aborted=%b want 25 1", obs_done, obs_aborted);
    end
    checks++;
    if (obs_rem != 6 || obs_ready_done !== 1'b1) begin
      errors++;
      $display("FAIL abort_state got rem=%0d ready=%b want 6 1", obs_rem, obs_ready_done);
    end
  endtask

  task automatic test_async_reset();
    int late_done;
    @(posedge clk); #1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_steps  = STEP_W'(8);
    bus.cmd_dir    = 1'b1;
    bus.cmd_period = PER_W'(4);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL arst_premove got busy=%b want 1", bus.busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.step_pulse !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL arst_flags got busy=%b ready=%b pulse=%b done=%b want 0 1 0 0",
               bus.busy, bus.cmd_ready, bus.step_pulse, bus.done);
    end
    checks++;
    if (bus.steps_remaining !== '0 || bus.step_dir !== 1'b0 || bus.aborted !== 1'b0) begin
      errors++;
      $display("FAIL arst_data got rem=%0d dir=%b aborted=%b want 0 0 0",
               bus.steps_remaining, bus.step_dir, bus.aborted);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    late_done = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.done) late_done++;
    end
    checks++;
    if (late_done != 0) begin
      errors++;
      $display("FAIL arst_no_done got %0d done pulses want 0", late_done);
    end
    run_move(8, 1'b1, 4, 0, 80, 1'b1);
    exp_pulses = {10, 18, 24, 28, 32, 38, 46, 56};
    checks++;
    if (obs_pulses.size() != exp_pulses.size()) begin
      errors++;
      $display("FAIL arst_rerun_count got %0d want %0d", obs_pulses.size(), exp_pulses.size());
    end
    for (int i = 0; i < exp_pulses.size() && i < obs_pulses.size(); i++) begin
      checks++;
      if (obs_pulses[i] != exp_pulses[i]) begin
        errors++;
        $display("FAIL arst_rerun_pulse%0d got cycle %0d want %0d", i, obs_pulses[i], exp_pulses[i]);
      end
    end
    checks++;
    if (obs_done != 57 || obs_aborted !== 1'b0 || !obs_dir_ok) begin
      errors++;
      $display("FAIL arst_rerun_done got cycle %0d aborted=%b dir_ok=%b want 57 0 1",
               obs_done, obs_aborted, obs_dir_ok);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      int steps, period, ab;
      bit dir;
      steps  = int'($urandom_range(0, 12));
      period = int'($urandom_range(0, 14));
      dir    = 1'($urandom_range(0, 1));
      model(steps, period, 0);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, exp_done + 1)) : 0;
      model(steps, period, ab);
      run_move(steps, dir, period, ab, exp_done + 5, 1'b1);
      checks++;
      if (obs_pulses.size() != exp_pulses.size()) begin
        errors++;
        $display("FAIL rand%0d_count steps=%0d per=%0d abort=%0d got %0d want %0d",
                 n, steps, period, ab, obs_pulses.size(), exp_pulses.size());
      end
      for (int i = 0; i < exp_pulses.size() && i < obs_pulses.size(); i++) begin
        checks++;
        if (obs_pulses[i] != exp_pulses[i]) begin
          errors++;
          $display("FAIL rand%0d_pulse%0d got cycle %0d want %0d", n, i, obs_pulses[i], exp_pulses[i]);
        end
      end
      checks++;
      if (obs_done != exp_done || obs_aborted !== exp_aborted) begin
        errors++;
        $display("FAIL rand%0d_done got cycle %0d aborted=%b want %0d %b",
                 n, obs_done, obs_aborted, exp_done, exp_aborted);
      end
      checks++;
      if (obs_rem != exp_rem || !obs_dir_ok) begin
        errors++;
        $display("FAIL rand%0d_rem got rem=%0d dir_ok=%b want %0d 1", n, obs_rem, obs_dir_ok, exp_rem);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_steps  = '0;
    bus.cmd_dir    = 1'b0;
    bus.cmd_period = '0;
    bus.abort      = 1'b0;
    test_reset();
    test_trapezoid();
    test_triangle();
    test_no_ramp();
    test_zero_and_min();
    test_abort();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_pulse_generator.md
Name: step_pulse_generator

Overview:
Upstream motion stage for the stepper phase controller. Accepts a move command (step count, direction, target period) over a valid/ready handshake. Emits one-cycle step pulses with a linear accelerate/cruise/decelerate period profile. The downstream phase sequencer advances one half-step per pulse, in the direction given by step_dir.

Parameters:
STEP_W, 16, width of step count and remaining counter
PER_W, 16, width of all period values (clock cycles per step)
START_PERIOD, 1000, period of first and last step of a ramp (slowest speed)
ACCEL_DEC, 10, period change per step while ramping
MIN_PERIOD, 2, floor applied to cmd_period

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid&&cmd_ready
cmd_steps  in  STEP_W  number of steps to issue
cmd_dir  in  1  direction, 1=forward
cmd_period  in  PER_W  target cruise period in cycles
abort  in  1  synchronous stop request
step_pulse  out  1  one-cycle step strobe to phase sequencer
step_dir  out  1  direction latched at accept; stable for the whole move
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at move end, normal or aborted
aborted  out  1  valid with done; 1 if the move ended by abort
steps_remaining  out  STEP_W  steps not yet issued

Behaviour:
- Reset (reset=0): state IDLE. cmd_ready=1. All other outputs are 0. Internal counters are 0.
- Accept edge:
  - Latch step_dir=cmd_dir and steps_remaining=cmd_steps.
  - target = max(cmd_period, MIN_PERIOD).
  - cur_period = max(START_PERIOD, target); ramp_cnt = 0.
  - Load the period counter with cur_period.
- cmd_steps=0: accepted; no pulses; done=1 (aborted=0) in the cycle after accept; then IDLE.
- States:
  - IDLE -> ACCEL on accept. Go to CRUISE instead if target >= START_PERIOD (no ramp).
  - ACCEL/CRUISE/DECEL -> IDLE after the last step, or on abort.
- Timing: step_pulse is high in the cycle that is cur_period cycles after the accept or after the previous pulse. The inter-pulse interval equals the period in force.
- On each pulse:
  - steps_remaining decrements; call the new value rem.
  - rem=0: done=1 next cycle, aborted=0, then IDLE.
  - Otherwise, if rem <= ramp_cnt (checked first, in any state): DECEL; cur_period = min(cur_period+ACCEL_DEC, START_PERIOD); ramp_cnt decrements, saturating at 0.
  - Else in ACCEL: cur_period = max(cur_period-ACCEL_DEC, target); ramp_cnt increments. Go to CRUISE when cur_period reaches target.
  - Else (CRUISE): period unchanged.
- Period arithmetic: performed in PER_W+1 bits, then clamped as above; no wrap.
- abort:
  - Sampled every cycle while busy.
  - Next edge: IDLE, done=1, aborted=1. steps_remaining holds its value until the next accept.
  - No step_pulse in the abort-sample cycle or after it, even if the counter expires in that same cycle. abort wins.
  - abort in IDLE is ignored.
- cmd_valid while busy: ignored (cmd_ready=0); no queuing.
- Reset mid-move: immediate return to reset values; no done pulse.

Decomposition:
- Shared package: state encoding (IDLE, ACCEL, CRUISE, DECEL) and period clamp helper functions.
- One natural sub-module: step_period_timer. It holds a loadable down-counter and emits an expire strobe; the profile logic in the parent reloads it.

Test Plan:
Bench overrides: START_PERIOD=10, ACCEL_DEC=2, MIN_PERIOD=2.
1. Trapezoid: accept steps=8, dir=1, period=4 at cycle 0 -> pulses at 10,18,24,28,32,38,46,56 (intervals 10,8,6,4,4,6,8,10); done at 57, aborted=0; step_dir=1 throughout.
2. Triangle: steps=4, period=4 -> intervals 10,8,6,8; done after 4th pulse; CRUISE never entered.
3. No ramp: steps=3, period=20 -> pulses at 20,40,60; done at 61.
4. Zero/minimum: steps=0 -> done at cycle 1, no pulse. Then steps=2, period=0 -> target clamped to 2; intervals 10,8.
5. Abort: steps=8, period=4; abort in cycle 24, coincident with the 3rd pulse -> no pulse at 24; done=1, aborted=1 at 25; steps_remaining=6; cmd_ready=1 at 25.
6. Async reset: reset low at cycle 15 of case 1 -> outputs 0 and cmd_ready=1 immediately; no done pulse. After release, a new command behaves as in case 1. cmd_valid pulses during busy are ignored.
